// File: rtl/decode_stage_hs.sv
// ---------------------------------------------------------------------------
// decode_stage_hs
//
// Instruction decode (ID) stage for RV32I / RV32E with valid/ready handshakes
// on both the IF side and the EX side. Holds the architectural register file
// (with optional write-back bypass). Resolves jumps and branches in ID. Stalls
// on load-use hazards and on branch/JALR operand hazards. Registers the decoded
// fields into the ID/EX pipeline register.
//
// Parameters
//   XLEN       data / PC width
//   NUM_REGS   architectural register count (32 = RV32I, 16 = RV32E)
//   WB_BYPASS  1: a same-cycle WB write is visible to ID reads
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clk_en                     global enable; all state holds when low
//   if_valid/if_ready          IF handshake; if_inst / if_pc carry the payload
//   wb_wr_en/wb_rd_addr/_data  register file write port (write-back)
//   mem_rd_wr_en/mem_rd_addr   destination of the instruction currently in MEM
//   flush                      kill the ID contents and the ID/EX register
//   ex_valid/ex_ready          EX handshake for the ID/EX register
//   ex_*                       registered decoded fields
//   ex_alu_src1                0 = RS1, 1 = PC
//   ex_alu_src2                0 = RS2, 1 = IMM
//   ex_alu_op                  {0, funct7[5], funct3} for ALU ops,
//                              5'b10000 = ADD4, 5'b10001 = BPS2 (pass operand 2)
//   branch_taken/jump_addr     combinational IF redirect
//   illegal_inst               registered with ex_valid; undecodable instruction
// ---------------------------------------------------------------------------
module decode_stage_hs #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            wb_wr_en,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            mem_rd_wr_en,
  input  logic [4:0]      mem_rd_addr,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_rd_wr_en,
  output logic            ex_mem_rd_en,
  output logic            ex_mem_wr_en,
  output logic [2:0]      ex_funct3,
  output logic            ex_alu_src1,
  output logic            ex_alu_src2,
  output logic [4:0]      ex_alu_op,
  output logic            branch_taken,
  output logic [XLEN-1:0] jump_addr,
  output logic            illegal_inst
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ALUI   = 7'b0010011,
    OP_ALU    = 7'b0110011
  } opcode_e;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_ADD4 = 5'b10000;
  localparam logic [4:0] ALU_BPS2 = 5'b10001;
  localparam logic       SRC1_RS1 = 1'b0;
  localparam logic       SRC1_PC  = 1'b1;
  localparam logic       SRC2_RS2 = 1'b0;
  localparam logic       SRC2_IMM = 1'b1;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = if_inst[6:0];
  assign rd     = if_inst[11:7];
  assign funct3 = if_inst[14:12];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];

  // Immediate formats (32-bit, sign carried in bit 31)
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                  if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'b0};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                  if_inst[30:21], 1'b0};

  // Decode
  logic               known, uses_rs1, uses_rs2, uses_rd;
  logic               is_jal, is_jalr, is_branch, is_load, is_store;
  logic [4:0]         alu_op;
  logic               alu_src1, alu_src2;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm;
  logic               illegal, dec_rd_wr_en, dec_mem_rd_en, dec_mem_wr_en;

  // NOTE: every variable written here gets a default first so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    known     = 1'b1;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    alu_op    = ALU_ADD;
    alu_src1  = SRC1_RS1;
    alu_src2  = SRC2_RS2;
    imm32     = imm_i;
    case (opcode)
      OP_LUI: begin
        uses_rd  = 1'b1;
        alu_op   = ALU_BPS2;
        alu_src2 = SRC2_IMM;
        imm32    = imm_u;
      end
      OP_AUIPC: begin
        uses_rd  = 1'b1;
        alu_src1 = SRC1_PC;
        alu_src2 = SRC2_IMM;
        imm32    = imm_u;
      end
      OP_JAL: begin
        uses_rd  = 1'b1;
        is_jal   = 1'b1;
        alu_op   = ALU_ADD4;
        alu_src1 = SRC1_PC;
        imm32    = imm_j;
      end
      OP_JALR: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        is_jalr  = 1'b1;
        alu_op   = ALU_ADD4;
        alu_src1 = SRC1_PC;
      end
      OP_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
        imm32     = imm_b;
      end
      OP_LOAD: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        is_load  = 1'b1;
        alu_src2 = SRC2_IMM;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        is_store = 1'b1;
        alu_op   = ALU_BPS2;
        imm32    = imm_s;
      end
      OP_ALUI: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        alu_src2 = SRC2_IMM;
        // Only the shift-right immediates carry an operation bit in funct7.
        alu_op   = {1'b0, (funct3 == 3'b101) ? if_inst[30] : 1'b0, funct3};
      end
      OP_ALU: begin
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        alu_op   = {1'b0, if_inst[30], funct3};
      end
      default: known = 1'b0;
    endcase
  end

  // Signed source sign-extends when XLEN is wider than 32.
  assign imm = XLEN'(imm32);

  // Register numbers at or above NUM_REGS do not exist (RV32E).
  assign illegal = ~known
                 | (uses_rs1 & (int'(rs1) >= NUM_REGS))
                 | (uses_rs2 & (int'(rs2) >= NUM_REGS))
                 | (uses_rd  & (int'(rd)  >= NUM_REGS));

  assign dec_rd_wr_en  = uses_rd & (rd != 5'd0) & ~illegal;
  assign dec_mem_rd_en = is_load & ~illegal;
  assign dec_mem_wr_en = is_store & ~illegal;

  // Register file, x0 is not stored
  logic [XLEN-1:0] regs [1:NUM_REGS-1];
  logic            rf_we;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign rf_we = clk_en & wb_wr_en & (wb_rd_addr != 5'd0)
               & (int'(wb_rd_addr) < NUM_REGS);

  // NOTE: the register file is reset because the architectural state after
  // reset is defined as all zeros; it is small enough to live in flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rf_we) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wb_rd_addr == 5'(i)) regs[i] <= wb_rd_data;
    end
  end

  // Out-of-range and x0 reads fall through to zero.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1 == 5'(i)) rs1_data = regs[i];
      if (rs2 == 5'(i)) rs2_data = regs[i];
    end
    if (WB_BYPASS && rf_we && (wb_rd_addr == rs1)) rs1_data = wb_rd_data;
    if (WB_BYPASS && rf_we && (wb_rd_addr == rs2)) rs2_data = wb_rd_data;
  end

  // Hazards
  logic load_use, br_hazard, stall, advance, accept;
  logic rs1_fwd_hit, rs2_fwd_hit;

  assign load_use = ex_valid & ex_mem_rd_en & (ex_rd_addr != 5'd0)
                  & ((uses_rs1 & (rs1 == ex_rd_addr))
                   | (uses_rs2 & (rs2 == ex_rd_addr)));

  // A branch/JALR operand still being produced in EX or MEM cannot be
  // compared in ID, so the instruction waits.
  assign rs1_fwd_hit = uses_rs1 & (rs1 != 5'd0)
                     & ((ex_valid & ex_rd_wr_en & (rs1 == ex_rd_addr))
                      | (mem_rd_wr_en & (rs1 == mem_rd_addr)));
  assign rs2_fwd_hit = uses_rs2 & (rs2 != 5'd0)
                     & ((ex_valid & ex_rd_wr_en & (rs2 == ex_rd_addr))
                      | (mem_rd_wr_en & (rs2 == mem_rd_addr)));
  assign br_hazard   = (is_branch | is_jalr) & (rs1_fwd_hit | rs2_fwd_hit);

  assign stall    = if_valid & (load_use | br_hazard);
  assign advance  = clk_en & (~ex_valid | ex_ready);
  assign if_ready = advance & ~stall & ~flush;
  assign accept   = if_valid & if_ready;

  // Branch resolution
  logic            cond;
  logic [XLEN-1:0] target;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  assign target       = (is_jalr ? rs1_data : if_pc) + imm;
  assign jump_addr    = is_jalr ? {target[XLEN-1:1], 1'b0} : target;
  assign branch_taken = accept & ~illegal
                      & (is_jal | is_jalr | (is_branch & cond));

  // ID/EX pipeline register
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_rd_addr   <= '0;
      ex_rd_wr_en  <= 1'b0;
      ex_mem_rd_en <= 1'b0;
      ex_mem_wr_en <= 1'b0;
      ex_funct3    <= '0;
      ex_alu_src1  <= SRC1_RS1;
      ex_alu_src2  <= SRC2_RS2;
      ex_alu_op    <= ALU_ADD;
      illegal_inst <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        ex_valid     <= 1'b0;
        illegal_inst <= 1'b0;
      end else if (advance) begin
        if (accept) begin
          ex_valid     <= 1'b1;
          ex_pc        <= if_pc;
          ex_imm       <= imm;
          ex_rs1_data  <= rs1_data;
          ex_rs2_data  <= rs2_data;
          ex_rd_addr   <= rd;
          ex_rd_wr_en  <= dec_rd_wr_en;
          ex_mem_rd_en <= dec_mem_rd_en;
          ex_mem_wr_en <= dec_mem_wr_en;
          ex_funct3    <= funct3;
          ex_alu_src1  <= alu_src1;
          ex_alu_src2  <= alu_src2;
          ex_alu_op    <= alu_op;
          illegal_inst <= illegal;
        end else begin
          ex_valid     <= 1'b0;
          illegal_inst <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_hs
//
// Directed bench for decode_stage_hs. dut_a is the RV32I build with the
// write-back bypass enabled. dut_b is an RV32E build (16 registers) without
// the bypass. Both DUTs share every input. Single-instruction decode is
// table driven; hazards, back-pressure, flush and reset use short hand-written
// sequences. Inputs change on the falling edge and are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_decode_stage_hs;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_ADD4 = 5'b10000;
  localparam logic [4:0] ALU_BPS2 = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_rd_addr = '0;
  logic [31:0] wb_rd_data = '0;
  logic        mem_rd_wr_en = 1'b0;
  logic [4:0]  mem_rd_addr = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;

  logic        a_if_ready, a_ex_valid, a_rd_wr, a_mrd, a_mwr, a_s1, a_s2, a_bt, a_ill;
  logic [31:0] a_pc, a_imm, a_rs1, a_rs2, a_jump;
  logic [4:0]  a_rd, a_op;
  logic [2:0]  a_f3;
  logic        b_if_ready, b_ex_valid, b_rd_wr, b_mrd, b_mwr, b_s1, b_s2, b_bt, b_ill;
  logic [31:0] b_pc, b_imm, b_rs1, b_rs2, b_jump;
  logic [4:0]  b_rd, b_op;
  logic [2:0]  b_f3;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .if_valid(if_valid), .if_ready(a_if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .mem_rd_wr_en(mem_rd_wr_en), .mem_rd_addr(mem_rd_addr), .flush(flush),
    .ex_valid(a_ex_valid), .ex_ready(ex_ready),
    .ex_pc(a_pc), .ex_imm(a_imm), .ex_rs1_data(a_rs1), .ex_rs2_data(a_rs2),
    .ex_rd_addr(a_rd), .ex_rd_wr_en(a_rd_wr), .ex_mem_rd_en(a_mrd),
    .ex_mem_wr_en(a_mwr), .ex_funct3(a_f3), .ex_alu_src1(a_s1),
    .ex_alu_src2(a_s2), .ex_alu_op(a_op), .branch_taken(a_bt),
    .jump_addr(a_jump), .illegal_inst(a_ill)
  );

  decode_stage_hs #(.XLEN(32), .NUM_REGS(16), .WB_BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .if_valid(if_valid), .if_ready(b_if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .mem_rd_wr_en(mem_rd_wr_en), .mem_rd_addr(mem_rd_addr), .flush(flush),
    .ex_valid(b_ex_valid), .ex_ready(ex_ready),
    .ex_pc(b_pc), .ex_imm(b_imm), .ex_rs1_data(b_rs1), .ex_rs2_data(b_rs2),
    .ex_rd_addr(b_rd), .ex_rd_wr_en(b_rd_wr), .ex_mem_rd_en(b_mrd),
    .ex_mem_wr_en(b_mwr), .ex_funct3(b_f3), .ex_alu_src1(b_s1),
    .ex_alu_src2(b_s2), .ex_alu_op(b_op), .branch_taken(b_bt),
    .jump_addr(b_jump), .illegal_inst(b_ill)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model_rf [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One register-file write through the WB port, with no instruction offered.
  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_wr_en   = 1'b1;
    wb_rd_addr = addr;
    wb_rd_data = data;
    @(posedge clk);
    #1;
    wb_wr_en = 1'b0;
    if (addr != 5'd0) model_rf[addr] = data;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bt;
    logic        chk_jump;
    logic [31:0] jump;
    logic [31:0] imm;
    logic [4:0]  op;
    logic        s1;
    logic        s2;
    logic        rdw;
    logic        mrd;
    logic        mwr;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;

    //            inst          pc            bt    chkj  jump          imm           op        s1    s2    rdw   mrd   mwr   ill
    vecs[0]  = '{32'h123451B7, 32'h00000010, 1'b0, 1'b0, 32'h0,        32'h12345000, ALU_BPS2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // LUI x3
    vecs[1]  = '{32'h00001217, 32'h00000040, 1'b0, 1'b0, 32'h0,        32'h00001000, ALU_ADD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // AUIPC x4
    vecs[2]  = '{32'h00628863, 32'h00000100, 1'b1, 1'b1, 32'h00000110, 32'h00000010, ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ x5,x6 (7==7)
    vecs[3]  = '{32'h00728863, 32'h00000100, 1'b0, 1'b0, 32'h0,        32'h00000010, ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ x5,x7 (7!=8)
    vecs[4]  = '{32'h00554863, 32'h00000100, 1'b1, 1'b1, 32'h00000110, 32'h00000010, ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BLT -1<7
    vecs[5]  = '{32'h00556863, 32'h00000100, 1'b0, 1'b0, 32'h0,        32'h00000010, ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // BLTU ffffffff<7
    vecs[6]  = '{32'h003100E7, 32'h00000300, 1'b1, 1'b1, 32'h00000202, 32'h00000003, ALU_ADD4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // JALR x1,x2,3
    vecs[7]  = '{32'h0080006F, 32'h00000500, 1'b1, 1'b1, 32'h00000508, 32'h00000008, ALU_ADD4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // JAL x0,+8
    vecs[8]  = '{32'h00412183, 32'h00000020, 1'b0, 1'b0, 32'h0,        32'h00000004, ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // LW x3,4(x2)
    vecs[9]  = '{32'hFE62AE23, 32'h00000024, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, ALU_BPS2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // SW x6,-4(x5)
    vecs[10] = '{32'h4013D413, 32'h00000028, 1'b0, 1'b0, 32'h0,        32'h00000401, 5'b01101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // SRAI x8,x7,1
    vecs[11] = '{32'h406284B3, 32'h0000002C, 1'b0, 1'b0, 32'h0,        32'h00000406, 5'b01000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // SUB x9,x5,x6
    vecs[12] = '{32'h0000007F, 32'h00000030, 1'b0, 1'b0, 32'h0,        32'h00000000, ALU_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // unknown opcode
    vecs[13] = '{32'h002088B3, 32'h00000034, 1'b0, 1'b0, 32'h0,        32'h00000002, ALU_ADD,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // ADD x17,x1,x2

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset ex_valid", a_ex_valid, 1'b0);
    check("reset ex_alu_op", a_op, ALU_ADD);
    check("reset ex_alu_src1", a_s1, 1'b0);
    check("reset ex_alu_src2", a_s2, 1'b0);
    check("reset illegal_inst", a_ill, 1'b0);
    check("reset ex_pc", a_pc, 32'h0);
    check("reset if_ready", a_if_ready, 1'b1);

    // ADDI x1,x0,5 then ADD x2,x1,x1 with WB x1=5 in the ADD's read cycle
    @(negedge clk);
    if_inst = 32'h00500093; if_pc = 32'h0; if_valid = 1'b1;
    #1 check("addi if_ready", a_if_ready, 1'b1);
    @(negedge clk);
    if_inst = 32'h00108133; if_pc = 32'h4;
    wb_wr_en = 1'b1; wb_rd_addr = 5'd1; wb_rd_data = 32'd5;
    #1;
    check("addi ex_valid", a_ex_valid, 1'b1);
    check("addi ex_imm", a_imm, 32'd5);
    check("addi ex_alu_src2", a_s2, 1'b1);
    check("addi ex_rd_wr_en", a_rd_wr, 1'b1);
    check("addi ex_rd_addr", a_rd, 5'd1);
    @(negedge clk);
    if_valid = 1'b0; wb_wr_en = 1'b0;
    model_rf[1] = 32'd5;
    #1;
    check("bypass a rs1", a_rs1, 32'd5);
    check("bypass a rs2", a_rs2, 32'd5);
    check("nobypass b rs1", b_rs1, 32'd0);
    check("nobypass b rs2", b_rs2, 32'd0);
    check("bypass ex_pc", a_pc, 32'h4);

    // Preload operands for the decode table
    wb_write(5'd2, 32'h00000200);
    wb_write(5'd5, 32'd7);
    wb_write(5'd6, 32'd7);
    wb_write(5'd7, 32'd8);
    wb_write(5'd10, 32'hFFFFFFFF);

    // Table-driven single-instruction decode, each followed by an idle cycle
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      if_inst = vecs[v].inst; if_pc = vecs[v].pc; if_valid = 1'b1;
      #1;
      check($sformatf("v%0d if_ready", v), a_if_ready, 1'b1);
      check($sformatf("v%0d branch_taken", v), a_bt, vecs[v].bt);
      if (vecs[v].chk_jump) check($sformatf("v%0d jump_addr", v), a_jump, vecs[v].jump);
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      ins = vecs[v].inst;
      check($sformatf("v%0d ex_valid", v), a_ex_valid, 1'b1);
      check($sformatf("v%0d ex_pc", v), a_pc, vecs[v].pc);
      check($sformatf("v%0d ex_imm", v), a_imm, vecs[v].imm);
      check($sformatf("v%0d ex_alu_op", v), a_op, vecs[v].op);
      check($sformatf("v%0d ex_alu_src1", v), a_s1, vecs[v].s1);
      check($sformatf("v%0d ex_alu_src2", v), a_s2, vecs[v].s2);
      check($sformatf("v%0d ex_rd_wr_en", v), a_rd_wr, vecs[v].rdw);
      check($sformatf("v%0d ex_mem_rd_en", v), a_mrd, vecs[v].mrd);
      check($sformatf("v%0d ex_mem_wr_en", v), a_mwr, vecs[v].mwr);
      check($sformatf("v%0d illegal_inst", v), a_ill, vecs[v].ill);
      check($sformatf("v%0d ex_rd_addr", v), a_rd, ins[11:7]);
      check($sformatf("v%0d ex_funct3", v), a_f3, ins[14:12]);
      check($sformatf("v%0d ex_rs1_data", v), a_rs1, model_rf[ins[19:15]]);
      check($sformatf("v%0d ex_rs2_data", v), a_rs2, model_rf[ins[24:20]]);
    end

    // Load-use: LW x3,0(x1) then ADD x4,x3,x1 -> one bubble
    @(negedge clk);
    if_inst = 32'h0000A183; if_pc = 32'h700; if_valid = 1'b1;
    @(negedge clk);
    if_inst = 32'h00118233; if_pc = 32'h704;
    #1;
    check("loaduse if_ready stalled", a_if_ready, 1'b0);
    check("loaduse lw in ex", a_mrd, 1'b1);
    @(negedge clk);
    #1;
    check("loaduse bubble ex_valid", a_ex_valid, 1'b0);
    check("loaduse if_ready released", a_if_ready, 1'b1);
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("loaduse add ex_valid", a_ex_valid, 1'b1);
    check("loaduse add ex_pc", a_pc, 32'h704);
    check("loaduse add rs2", a_rs2, 32'd5);

    // Branch operand hazard against the MEM destination
    @(negedge clk);
    if_inst = 32'h00628863; if_pc = 32'h100; if_valid = 1'b1;
    mem_rd_wr_en = 1'b1; mem_rd_addr = 5'd5;
    #1;
    check("brhaz if_ready", a_if_ready, 1'b0);
    check("brhaz branch_taken", a_bt, 1'b0);
    @(negedge clk);
    mem_rd_wr_en = 1'b0;
    #1;
    check("brhaz cleared if_ready", a_if_ready, 1'b1);
    check("brhaz cleared branch_taken", a_bt, 1'b1);
    @(negedge clk);
    if_valid = 1'b0;

    // EX back-pressure for 3 cycles, then flush
    @(negedge clk);
    if_inst = 32'h00500093; if_pc = 32'h600; if_valid = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    if_inst = 32'h0080006F; if_pc = 32'h604;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("hold%0d if_ready", k), a_if_ready, 1'b0);
      check($sformatf("hold%0d branch_taken", k), a_bt, 1'b0);
      check($sformatf("hold%0d ex_valid", k), a_ex_valid, 1'b1);
      check($sformatf("hold%0d ex_pc", k), a_pc, 32'h600);
      check($sformatf("hold%0d ex_imm", k), a_imm, 32'd5);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("flush if_ready", a_if_ready, 1'b0);
    check("flush branch_taken", a_bt, 1'b0);
    @(negedge clk);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    #1;
    check("flush ex_valid", a_ex_valid, 1'b0);

    // RV32E: ADD x17,x1,x2 is illegal on dut_b only
    @(negedge clk);
    if_inst = 32'h002088B3; if_pc = 32'h800; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("rv32e ex_valid", b_ex_valid, 1'b1);
    check("rv32e illegal_inst", b_ill, 1'b1);
    check("rv32e ex_rd_wr_en", b_rd_wr, 1'b0);
    check("rv32i illegal_inst", a_ill, 1'b0);

    // WB to x20: kept by dut_a, ignored by dut_b
    wb_write(5'd20, 32'h0000DEAD);
    @(negedge clk);
    if_inst = 32'h000A0233; if_pc = 32'h804; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("x20 a rs1", a_rs1, 32'h0000DEAD);
    check("x20 b rs1", b_rs1, 32'h0);

    // x0 reads zero even with a same-cycle WB write to x0
    @(negedge clk);
    if_inst = 32'h00000233; if_pc = 32'h808; if_valid = 1'b1;
    wb_wr_en = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h55;
    @(negedge clk);
    if_valid = 1'b0; wb_wr_en = 1'b0;
    #1;
    check("x0 a rs1", a_rs1, 32'h0);
    check("x0 a rs2", a_rs2, 32'h0);
    check("x0 b rs1", b_rs1, 32'h0);

    // Reset in the middle of operation
    @(negedge clk);
    if_inst = 32'h00028233; if_pc = 32'h900; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("prereset ex_valid", a_ex_valid, 1'b1);
    check("prereset rs1", a_rs1, 32'd7);
    rst_n = 1'b0;
    #1;
    check("midreset a ex_valid", a_ex_valid, 1'b0);
    check("midreset b ex_valid", b_ex_valid, 1'b0);
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_inst = 32'h00028233; if_pc = 32'h904; if_valid = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("postreset ex_valid", a_ex_valid, 1'b1);
    check("postreset rs1 cleared", a_rs1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
